// File: rtl/pipe_control_unit_if.sv
// rtl/pipe_control_unit_if.sv - ID-stage inputs and pipeline control outputs of pipe_control_unit
interface pipe_control_unit_if #(
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [5:0]      id_opcode;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            ex_zero;

  logic            id_jump;
  logic            id_illegal;
  logic            ex_alu_src;
  logic            ex_reg_dst;
  logic            ex_beq;
  logic            ex_bne;
  logic [1:0]      ex_alu_op;
  logic [RA_W-1:0] ex_rt;
  logic            mem_read;
  logic            mem_write;
  logic            wb_mem_to_reg;
  logic            wb_reg_write;
  logic            pc_src;
  logic            pc_write;
  logic            if_id_write;
  logic            if_id_flush;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, ex_zero,
    input  id_jump, id_illegal, ex_alu_src, ex_reg_dst, ex_beq, ex_bne, ex_alu_op, ex_rt,
           mem_read, mem_write, wb_mem_to_reg, wb_reg_write,
           pc_src, pc_write, if_id_write, if_id_flush
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, ex_zero,
    output id_jump, id_illegal, ex_alu_src, ex_reg_dst, ex_beq, ex_bne, ex_alu_op, ex_rt,
           mem_read, mem_write, wb_mem_to_reg, wb_reg_write,
           pc_src, pc_write, if_id_write, if_id_flush
  );
endinterface

// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - pipelined MIPS main control with load-use stall, branch flush and jump
// Optional PERF_CNT_EN adds saturating stall_cnt / flush_cnt counters.
module pipe_control_unit #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_control_unit_if.slave  bus
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
`endif
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic       d_alu_src, d_reg_dst, d_beq, d_bne, d_jump;
  logic       d_mem_read, d_mem_write, d_mem_to_reg, d_reg_write;
  logic [1:0] d_alu_op;
  logic       known, uses_rt;
  logic       ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic       mem_mem_to_reg, mem_reg_write;
  logic       hz, stall, bubble;
  logic [RA_W-1:0] rt_next;

  always_comb begin
    d_alu_src    = 1'b0;
    d_reg_dst    = 1'b0;
    d_beq        = 1'b0;
    d_bne        = 1'b0;
    d_jump       = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_reg_write  = 1'b0;
    d_alu_op     = 2'b00;
    known        = 1'b1;
    uses_rt      = 1'b0;
    case (bus.id_opcode)
      OP_R:   begin d_alu_op = 2'b10; d_reg_dst = 1'b1; d_reg_write = 1'b1; uses_rt = 1'b1; end
      OP_J:   begin d_alu_op = 2'b11; d_jump = 1'b1; end
      OP_BEQ: begin d_alu_op = 2'b01; d_beq = 1'b1; uses_rt = 1'b1; end
      OP_BNE: begin d_alu_op = 2'b01; d_bne = 1'b1; uses_rt = 1'b1; end
      OP_LW:  begin d_alu_src = 1'b1; d_mem_read = 1'b1; d_mem_to_reg = 1'b1; d_reg_write = 1'b1; end
      OP_SW:  begin d_alu_src = 1'b1; d_mem_write = 1'b1; uses_rt = 1'b1; end
      default: known = 1'b0;
    endcase
  end

  assign bus.id_illegal = bus.id_valid & ~known;
  assign bus.pc_src     = (bus.ex_beq & bus.ex_zero) | (bus.ex_bne & ~bus.ex_zero);

  // The load in EX must not feed the instruction in ID; a taken branch squashes ID anyway.
  assign hz = ex_mem_read & (bus.ex_rt != '0) & bus.id_valid &
              ((bus.ex_rt == bus.id_rs) | (uses_rt & (bus.ex_rt == bus.id_rt)));
  assign stall  = hz & ~bus.pc_src;
  assign bubble = bus.pc_src | stall | ~bus.id_valid;

  assign bus.id_jump     = bus.id_valid & d_jump & ~bus.pc_src & ~stall;
  assign bus.if_id_flush = bus.pc_src | bus.id_jump;
  assign bus.pc_write    = ~stall;
  assign bus.if_id_write = ~stall;
  assign rt_next         = (bus.pc_src | stall) ? '0 : bus.id_rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_alu_src <= 1'b0;
      bus.ex_reg_dst <= 1'b0;
      bus.ex_beq     <= 1'b0;
      bus.ex_bne     <= 1'b0;
      bus.ex_alu_op  <= 2'b00;
      bus.ex_rt      <= '0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_reg_write   <= 1'b0;
    end else begin
      bus.ex_alu_src <= d_alu_src    & ~bubble;
      bus.ex_reg_dst <= d_reg_dst    & ~bubble;
      bus.ex_beq     <= d_beq        & ~bubble;
      bus.ex_bne     <= d_bne        & ~bubble;
      bus.ex_alu_op  <= d_alu_op     & {2{~bubble}};
      bus.ex_rt      <= rt_next;
      ex_mem_read    <= d_mem_read   & ~bubble;
      ex_mem_write   <= d_mem_write  & ~bubble;
      ex_mem_to_reg  <= d_mem_to_reg & ~bubble;
      ex_reg_write   <= d_reg_write  & ~bubble;
    end
  end

  // EX/MEM and MEM/WB always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      mem_mem_to_reg    <= 1'b0;
      mem_reg_write     <= 1'b0;
      bus.wb_mem_to_reg <= 1'b0;
      bus.wb_reg_write  <= 1'b0;
    end else begin
      bus.mem_read      <= ex_mem_read;
      bus.mem_write     <= ex_mem_write;
      mem_mem_to_reg    <= ex_mem_to_reg;
      mem_reg_write     <= ex_reg_write;
      bus.wb_mem_to_reg <= mem_mem_to_reg;
      bus.wb_reg_write  <= mem_reg_write;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (bus.if_id_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Pipelined main-control unit for the five-stage MIPS core.
- Decodes the ID-stage opcode and carries control bits through ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards, resolves beq/bne in EX, and generates stall, flush and PC-select for the datapath.
- Generalises the single-cycle decoder with a parametrised register-address width and hazard/flush sequencing.

Parameters:
RA_W, 5, register-specifier width for rs/rt hazard compare
CNT_W, 16, width of performance counters (PERF_CNT_EN only)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a valid instruction
id_opcode  in  6  ID-stage opcode
id_rs  in  RA_W  ID-stage rs field
id_rt  in  RA_W  ID-stage rt field
ex_zero  in  1  EX-stage ALU zero (operands equal)
id_jump  out  1  jump taken in ID (combinational)
id_illegal  out  1  valid unknown opcode in ID (combinational)
ex_alu_src, ex_reg_dst, ex_beq, ex_bne  out  1 each  ID/EX control
ex_alu_op  out  2  ID/EX ALUOp: 00 lw/sw, 01 branch, 10 R-type, 11 jump
ex_rt  out  RA_W  ID/EX rt copy
mem_read, mem_write  out  1 each  EX/MEM control
wb_mem_to_reg, wb_reg_write  out  1 each  MEM/WB control
pc_src  out  1  EX branch taken (combinational)
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID update enable
if_id_flush  out  1  squash IF/ID contents
stall_cnt, flush_cnt  out  CNT_W each  counters (PERF_CNT_EN only)

Behaviour:
- Decode table:
  - beq 000100: ALUOp 01, Beq.
  - bne 000101: ALUOp 01, Bne.
  - j 000010: ALUOp 11, Jump.
  - lw 100011: ALUOp 00, ALUSrc, MemRead, MemToReg, RegWrite.
  - sw 101011: ALUOp 00, ALUSrc, MemWrite.
  - R-type 000000: ALUOp 10, RegDst, RegWrite.
  - All unlisted signals are 0.
- Unknown opcode: all controls 0 (bubble); id_illegal=1 when id_valid=1.
- id_valid=0 decodes as bubble: all controls 0, ALUOp 00.
- Latency: fields decoded in cycle n appear on ex_* at n+1, mem_* at n+2, wb_* at n+3. EX/MEM and MEM/WB always advance; they never stall.
- Reset (async, rst_n=0): all ex_/mem_/wb_ outputs 0, ex_alu_op=00, ex_rt=0, counters 0. On release, the first edge loads normally.
- uses_rt = opcode is R-type, beq, bne or sw.
- Load-use stall: hz = ex_mem_read_internal & (ex_rt!=0) & (ex_rt==id_rs | (uses_rt & ex_rt==id_rt)) & id_valid.
  - When hz=1 and pc_src=0: pc_write=0, if_id_write=0, ID/EX loads bubble, id_jump forced 0.
  - Stall lasts exactly one cycle, because the bubble clears the EX mem_read.
- pc_src = (ex_beq & ex_zero) | (ex_bne & ~ex_zero).
  - When pc_src=1: if_id_flush=1, ID/EX loads bubble, pc_write=1, if_id_write=1, id_jump forced 0.
  - Branch has priority over stall and jump.
- Jump: id_jump=1 for a valid j with pc_src=0. if_id_flush=1 in that cycle. The j itself proceeds into ID/EX with ALUOp 11 and no writes.
- Default with no event: pc_write=1, if_id_write=1, if_id_flush=0.
- All combinational outputs are free of latches; every output is assigned on every path.

Optional Feature:
PERF_CNT_EN:
- Defined: stall_cnt increments on every cycle with stall asserted; flush_cnt increments on every cycle with if_id_flush=1. Both saturate at all-ones and reset to 0.
- Undefined: both ports are absent and no counter logic is built.

Test Plan:
- Reset: assert rst_n=0 mid-stream with pipeline full of lw -> all ex_/mem_/wb_ outputs 0 immediately, pc_write=1 after release.
- Latency: lw (100011) then R-type with unrelated regs -> mem_read=1 at n+2, wb_mem_to_reg=1 and wb_reg_write=1 at n+3; R-type wb_reg_write=1 at n+4; no stall.
- Load-use: lw ex_rt=5, then R-type id_rs=5 -> pc_write=0 and if_id_write=0 for exactly one cycle, ID/EX bubble, R-type issues next cycle. Repeat with ex_rt=0 -> no stall.
- Branch: beq in EX with ex_zero=1 while lw-use stall is pending in ID -> pc_src=1, if_id_flush=1, pc_write=1, ID/EX bubble. bne with ex_zero=1 -> pc_src=0.
- Jump: valid j in ID -> id_jump=1, if_id_flush=1; same cycle with taken branch in EX -> id_jump=0. Opcode 111111 with id_valid=1 -> id_illegal=1, all controls 0.
- PERF_CNT_EN: 3 load-use stalls and 2 flushes -> stall_cnt=3, flush_cnt=2. Force CNT_W=2 with 5 stalls -> stall_cnt=3 (saturated).
